// File: rtl/ysyx_25020047_mem_arb.sv
// Two-requester memory arbiter for the NPC core: shares one memory port between IFU and LSU,
// one transaction in flight, round-robin on contention, watchdog turns hung accesses into errors.
module ysyx_25020047_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          last_owner;
    logic          owner_q;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          wen_q, err_q;
    logic [3:0]    wmask_q;
    logic          grant_ifu, grant_lsu;
    logic          timeout_hit;
    logic          lsu_store;

    // Grants depend only on requester valids and state; on a tie the last owner yields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == S_IDLE) begin
            grant_ifu = ifu_req_valid && (!lsu_req_valid || last_owner);
            grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_owner);
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == LAST_CNT);
    assign lsu_store   = grant_lsu && lsu_wen;

    // Timeout beats a late acceptance in REQ; a real response beats the timeout in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant_ifu || grant_lsu) state_nxt = S_REQ;
            S_REQ: begin
                if (timeout_hit)        state_nxt = S_RESP;
                else if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: if (mem_resp_valid || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner_q <= grant_lsu;
                        addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_q   <= lsu_store;
                        wdata_q <= lsu_store ? lsu_wdata : 32'h0;
                        wmask_q <= lsu_store ? lsu_wmask : 4'h0;
                        cnt     <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (state_nxt == S_RESP) begin
                        if (state == S_WAIT && mem_resp_valid) begin
                            rdata_q <= wen_q ? 32'h0 : mem_rdata;
                            err_q   <= mem_err;
                        end else begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    last_owner <= owner_q;
                    rdata_q    <= 32'h0;
                    err_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;

    assign mem_req_valid  = (state == S_REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    assign ifu_resp_valid = (state == S_RESP) && !owner_q;
    assign lsu_resp_valid = (state == S_RESP) && owner_q;
    assign ifu_rdata      = ifu_resp_valid ? rdata_q : 32'h0;
    assign ifu_err        = ifu_resp_valid && err_q;
    assign lsu_rdata      = lsu_resp_valid ? rdata_q : 32'h0;
    assign lsu_err        = lsu_resp_valid && err_q;

    assign busy           = (state != S_IDLE);
    assign owner          = owner_q;

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Bench for ysyx_25020047_mem_arb: a transaction-level timeline model predicts every output
// each cycle from arrival/stall/response times; directed cases pin the model with literals.
module tb_ysyx_25020047_mem_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_err;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_err;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic [3:0]  lsu_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wmask;
    logic        busy, owner;

    always #5 clk = ~clk;

    ysyx_25020047_mem_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .busy(busy), .owner(owner)
    );

    // One accepted transaction on the model timeline: accepted at acc, memory accepts after
    // s stall cycles, responds d cycles later; r is the cycle of the response pulse.
    typedef struct {
        int          acc, s, d, r;
        bit          owner, timeout, wen;
        logic [31:0] addr, wdata, rdata_drv;
        logic [3:0]  wmask;
        logic        err_drv;
    } txn_t;

    txn_t tx;
    bit   have = 0, last_owner_m = 1, owner_m = 0;
    int   cyc = 0, n_checks = 0, n_errors = 0;

    bit          d_ifu_v = 0, d_lsu_v = 0, d_lsu_wen = 0;
    logic [31:0] d_ifu_addr = '0, d_lsu_addr = '0, d_lsu_wdata = '0;
    logic [3:0]  d_lsu_wmask = '0;
    bit          plan_rand = 0;
    int          plan_s = 0, plan_d = 1;
    logic [31:0] plan_rdata = '0;
    logic        plan_err = 0;

    int          n_ifu_pulse = 0, n_lsu_pulse = 0, last_ifu_t = 0, last_lsu_t = 0, n_grants = 0;
    logic [31:0] last_ifu_rdata, last_lsu_rdata, last_mem_addr, last_mem_wdata;
    logic        last_ifu_err, last_lsu_err, last_mem_wen;
    logic [3:0]  last_mem_wmask;
    logic [5:0]  grants = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit          in_req, in_wait, pulse, idle, gi, gl, resp, rv_i, rv_l;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          t;
        @(negedge clk);
        t = cyc;
        ifu_req_valid = d_ifu_v;  ifu_addr  = d_ifu_addr;
        lsu_req_valid = d_lsu_v;  lsu_addr  = d_lsu_addr;
        lsu_wen       = d_lsu_wen; lsu_wdata = d_lsu_wdata; lsu_wmask = d_lsu_wmask;
        in_req  = have && t >= tx.acc + 1 && t <= tx.acc + 1 + tx.s && t < tx.r;
        in_wait = have && t >= tx.acc + 2 + tx.s && t <= tx.r - 1;
        pulse   = have && t == tx.acc + 1 + tx.s + tx.d;
        mem_req_ready  = in_req ? (t == tx.acc + 1 + tx.s) : 1'($urandom_range(0, 1));
        mem_resp_valid = pulse ? 1'b1 : ((in_req || in_wait) ? 1'b0 : ($urandom_range(0, 3) == 0));
        mem_rdata      = pulse ? tx.rdata_drv : $urandom;
        mem_err        = pulse ? tx.err_drv : 1'($urandom_range(0, 1));
        #1;
        idle = !have || t > tx.r;
        gi   = idle && d_ifu_v && (!d_lsu_v || last_owner_m);
        gl   = idle && d_lsu_v && (!d_ifu_v || !last_owner_m);
        resp = have && t == tx.r;
        rv_i = resp && !tx.owner;
        rv_l = resp && tx.owner;
        exp_rdata = (tx.timeout || tx.wen) ? 32'h0 : tx.rdata_drv;
        exp_err   = tx.timeout ? 1'b1 : tx.err_drv;

        check("ifu_req_ready", 32'(ifu_req_ready), 32'(gi));
        check("lsu_req_ready", 32'(lsu_req_ready), 32'(gl));
        check("busy", 32'(busy), 32'(!idle));
        check("owner", 32'(owner), 32'(owner_m));
        check("mem_req_valid", 32'(mem_req_valid), 32'(in_req));
        if (in_req) begin
            check("mem_addr", mem_addr, tx.addr);
            check("mem_wen", 32'(mem_wen), 32'(tx.wen));
            check("mem_wmask", 32'(mem_wmask), 32'(tx.wmask));
            if (tx.wen || !tx.owner) check("mem_wdata", mem_wdata, tx.wdata);
        end
        check("ifu_resp_valid", 32'(ifu_resp_valid), 32'(rv_i));
        check("ifu_rdata", ifu_rdata, rv_i ? exp_rdata : 32'h0);
        check("ifu_err", 32'(ifu_err), 32'(rv_i && exp_err));
        check("lsu_resp_valid", 32'(lsu_resp_valid), 32'(rv_l));
        check("lsu_rdata", lsu_rdata, rv_l ? exp_rdata : 32'h0);
        check("lsu_err", 32'(lsu_err), 32'(rv_l && exp_err));

        if (ifu_resp_valid) begin
            n_ifu_pulse++; last_ifu_t = t; last_ifu_rdata = ifu_rdata; last_ifu_err = ifu_err;
        end
        if (lsu_resp_valid) begin
            n_lsu_pulse++; last_lsu_t = t; last_lsu_rdata = lsu_rdata; last_lsu_err = lsu_err;
        end
        if (mem_req_valid) begin
            last_mem_addr = mem_addr; last_mem_wen = mem_wen;
            last_mem_wdata = mem_wdata; last_mem_wmask = mem_wmask;
        end
        if (ifu_req_ready) begin grants = {grants[4:0], 1'b0}; n_grants++; end
        if (lsu_req_ready) begin grants = {grants[4:0], 1'b1}; n_grants++; end

        if (gi || gl) begin
            tx.acc   = t;
            tx.owner = gl;
            tx.addr  = gl ? d_lsu_addr : d_ifu_addr;
            tx.wen   = gl && d_lsu_wen;
            tx.wdata = tx.wen ? d_lsu_wdata : 32'h0;
            tx.wmask = tx.wen ? d_lsu_wmask : 4'h0;
            if (plan_rand) begin
                tx.s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
                tx.d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 4));
                tx.rdata_drv = $urandom;
                tx.err_drv   = ($urandom_range(0, 7) == 0);
            end else begin
                tx.s = plan_s; tx.d = plan_d; tx.rdata_drv = plan_rdata; tx.err_drv = plan_err;
            end
            tx.timeout = (TO != 0) && (tx.s + tx.d > TO - 1);
            tx.r = tx.timeout ? t + 1 + TO : t + 2 + tx.s + tx.d;
            owner_m = gl; last_owner_m = gl; have = 1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        d_ifu_v = 0; d_lsu_v = 0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        have = 0; last_owner_m = 1; owner_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int extra);
        int k = 0;
        d_ifu_v = 0; d_lsu_v = 0;
        while (have && cyc <= tx.r && k < 64) begin run_cycle(); k++; end
        check("drain_bound", 32'(k < 64), 32'd1);
        repeat (extra) run_cycle();
    endtask

    task automatic set_plan(input int s, input int d, input logic [31:0] rd);
        plan_rand = 0; plan_s = s; plan_d = d; plan_rdata = rd; plan_err = 1'b0;
    endtask

    initial begin
        int acc, pi, pl, k;

        // Reset state
        do_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_resp", 32'({ifu_resp_valid, lsu_resp_valid, ifu_err, lsu_err}), 32'd0);

        // Single IFU fetch, memory ready at once, response one cycle later
        set_plan(0, 1, 32'h0010_0093);
        d_ifu_v = 1; d_ifu_addr = 32'h8000_0000;
        pi = n_ifu_pulse;
        run_cycle();
        acc = tx.acc;
        drain(1);
        check("fetch_latency", last_ifu_t - acc, 32'd3);
        check("fetch_rdata", last_ifu_rdata, 32'h0010_0093);
        check("fetch_err", 32'(last_ifu_err), 32'd0);
        check("fetch_wmask", 32'(last_mem_wmask), 32'd0);
        check("fetch_pulses", n_ifu_pulse - pi, 32'd1);

        // LSU sb at 0x80001003
        set_plan(0, 1, 32'hDEAD_BEEF);
        d_lsu_v = 1; d_lsu_addr = 32'h8000_1003; d_lsu_wen = 1;
        d_lsu_wdata = 32'h0000_00AB; d_lsu_wmask = 4'b1000;
        pi = n_ifu_pulse; pl = n_lsu_pulse;
        run_cycle();
        drain(2);
        check("sb_addr", last_mem_addr, 32'h8000_1003);
        check("sb_wen", 32'(last_mem_wen), 32'd1);
        check("sb_wmask", 32'(last_mem_wmask), 32'h8);
        check("sb_wdata", last_mem_wdata, 32'h0000_00AB);
        check("sb_rdata", last_lsu_rdata, 32'd0);
        check("sb_lsu_pulses", n_lsu_pulse - pl, 32'd1);
        check("sb_ifu_pulses", n_ifu_pulse - pi, 32'd0);

        // Both requesters always valid from reset: strict alternation starting with IFU
        do_reset();
        set_plan(0, 1, 32'h1234_5678);
        d_ifu_v = 1; d_lsu_v = 1; d_lsu_wen = 0; d_ifu_addr = 32'h8000_0100; d_lsu_addr = 32'h8000_2000;
        grants = '0; n_grants = 0; k = 0;
        while (n_grants < 6 && k < 60) begin run_cycle(); k++; end
        drain(1);
        check("rr_count", n_grants, 32'd6);
        check("rr_order", 32'(grants), 32'b010101);

        // Memory stalls acceptance for 3 cycles
        set_plan(3, 1, 32'h0badc0de);
        d_ifu_v = 1; d_ifu_addr = 32'h8000_0040;
        run_cycle();
        acc = tx.acc;
        drain(1);
        check("stall_latency", last_ifu_t - acc, 32'd6);
        check("stall_rdata", last_ifu_rdata, 32'h0badc0de);

        // LSU load that memory never answers in time; late response lands after the timeout
        set_plan(0, TO + 1, 32'hFFFF_FFFF);
        d_lsu_v = 1; d_lsu_wen = 0; d_lsu_addr = 32'h8000_3000;
        pl = n_lsu_pulse;
        run_cycle();
        acc = tx.acc;
        drain(4);
        check("to_latency", last_lsu_t - (acc + 1), 32'd8);
        check("to_err", 32'(last_lsu_err), 32'd1);
        check("to_rdata", last_lsu_rdata, 32'd0);
        check("to_pulses", n_lsu_pulse - pl, 32'd1);

        // Randomized traffic against the timeline model
        plan_rand = 1;
        repeat (1500) begin
            d_ifu_v = ($urandom_range(0, 1) == 1);
            d_lsu_v = ($urandom_range(0, 1) == 1);
            d_ifu_addr = $urandom; d_lsu_addr = $urandom; d_lsu_wdata = $urandom;
            d_lsu_wen = ($urandom_range(0, 1) == 1);
            d_lsu_wmask = 4'($urandom_range(0, 15));
            run_cycle();
        end
        drain(1);

        // Reset pulsed while an LSU load is in WAIT
        set_plan(0, 6, 32'h5555_AAAA);
        d_lsu_v = 1; d_lsu_wen = 0; d_lsu_addr = 32'h8000_4000;
        run_cycle();
        d_lsu_v = 0;
        repeat (3) run_cycle();
        pi = n_ifu_pulse; pl = n_lsu_pulse;
        #1 rst_n = 1'b0;
        #1;
        have = 0; last_owner_m = 1; owner_m = 0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_lsu_resp", 32'({lsu_resp_valid, lsu_err}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_plan(0, 1, 32'h0000_0013);
        d_ifu_v = 1; d_ifu_addr = 32'h8000_0000;
        run_cycle();
        drain(3);
        check("post_rst_ifu_pulses", n_ifu_pulse - pi, 32'd1);
        check("post_rst_ifu_rdata", last_ifu_rdata, 32'h0000_0013);
        check("post_rst_lsu_pulses", n_lsu_pulse - pl, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ysyx_25020047_mem_arb.md
# ysyx_25020047_mem_arb

Two-requester memory arbiter and transaction sequencer for the NPC core. It shares the core's single memory port between the IFU (instruction fetch) and the LSU, which carries the load/store traffic (lw/lh/lhu/lb/lbu, sw/sh/sb) whose addresses the EXU computes. It allows one transaction in flight, grants round-robin on contention, holds the memory request until accepted and returns a one-cycle registered response to the owner. A watchdog converts hung transactions into error responses.

## Interface
- TIMEOUT, 255: max cycles in REQ+WAIT before forced error response; 0 disables the watchdog.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_resp_valid  out  1  one-cycle response pulse to IFU.
- ifu_rdata  out  32  fetched word.
- ifu_err  out  1  access fault/timeout, valid with ifu_resp_valid.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  byte enables (sb 0001<<a[1:0], sh 0011<<a[1:0], sw 1111).
- lsu_resp_valid  out  1  one-cycle response pulse to LSU (stores too).
- lsu_rdata  out  32  load data, 0 for stores.
- lsu_err  out  1  fault/timeout flag.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32
- mem_wen  out  1
- mem_wdata  out  32
- mem_wmask  out  4  0000 for IFU and LSU loads.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  32
- mem_err  in  1
- busy  out  1  state != IDLE.
- owner  out  1  0 = IFU, 1 = LSU; owner of current/last transaction.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if exactly one requester is valid, assert its ready combinationally, latch addr/wen/wdata/wmask and owner, then go to REQ. If both are valid, grant the requester that is not last_owner and assert only that ready. With no request, stay in IDLE.
- IFU transactions are forced to wen=0, wmask=0000, wdata=0.
- REQ: mem_req_valid=1 with latched fields held stable. On mem_req_ready go to WAIT.
- WAIT: on mem_resp_valid, register rdata (0 if the transaction was a store) and err into the owner's outputs, then go to RESP.
- RESP: the owner's resp_valid is high for exactly one cycle. last_owner <= owner. Go to IDLE.
- No new request is accepted in REQ, WAIT or RESP; both readies are 0.
- Watchdog: a counter clears on entering REQ and increments each cycle in REQ/WAIT. When counter == TIMEOUT-1 and no mem_resp_valid that cycle, go to RESP with err=1 and rdata=0. mem_req_valid may drop without acceptance on this path only.
- Simultaneous response and timeout: the response wins (err=mem_err).
- mem_resp_valid outside WAIT is ignored. A late response after a timeout is dropped.
- The non-owner's resp_valid, rdata and err stay 0.

## Timing
- Reset (async assert, sync release): state=IDLE, last_owner=1 (LSU, so IFU wins the first tie), counter=0, owner=0, busy=0. All *_ready, *_resp_valid, *_rdata, *_err and mem_* outputs are 0.
- Reset mid-transaction abandons it with no response pulse; mem_req_valid drops immediately.
- Minimum latency: accept at cycle N, mem_req_valid at N+1 (ready same cycle), mem_resp_valid at N+2, resp_valid at N+3, next accept possible at N+4.
- Memory must not respond in the same cycle it accepts a request.
- Readies depend combinationally on the requester valids and the state only, never on mem_* inputs.

## Test plan
- Single IFU fetch at 0x80000000, memory ready immediately and responding 0x00100093 one cycle later: ifu_resp_valid at N+3 with rdata 0x00100093, err=0, mem_wmask=0000.
- LSU sb at 0x80001003 with wdata 0xAB, wmask 1000: mem_wen=1, mem_wmask=1000, addr 0x80001003. lsu_resp_valid pulses once with rdata=0 and ifu_resp_valid stays 0.
- Both requesters valid every cycle for 6 transactions from reset: grants IFU, LSU, IFU, LSU, IFU, LSU, and each ready is asserted only with its grant.
- mem_req_ready held low for 3 cycles: address and data stay stable while mem_req_valid is high; the response arrives and latency grows by 3.
- TIMEOUT=8, memory never responds to an LSU load: lsu_resp_valid with err=1 and rdata=0 at 8 cycles after REQ entry. A mem_resp_valid injected 2 cycles later is ignored.
- rst_n pulsed low during WAIT: all outputs go to 0 immediately, there is no response pulse, and an IFU request after release completes normally.
